// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_entry
//  Description : 4x4 matrix keypad scanner with debounce and decimal operand
//                entry. Rows are driven active-low one at a time. A detected
//                column is debounced, and each accepted key produces a
//                one-cycle key_valid. Digits build an 8-bit operand, which
//                saturates by ignoring any digit that would overflow. The
//                +, - and * keys select a pending operation. = pulses
//                eq_pulse and then clears the entry, and C clears it at once.
//  Ports       : clk_scan   - scan clock (only clock)
//                rst        - asynchronous active-high reset
//                row        - row drive, active-low one-hot
//                col        - column sense, active-low
//                key_code   - code of last accepted key
//                key_valid  - one-cycle pulse per accepted key
//                num_input  - operand being entered (binary)
//                op_display - pending op: 0 none, 1 +, 2 -, 3 *
//                eq_pulse   - one-cycle pulse on =
//                clr_pulse  - one-cycle pulse on C
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry #(
    parameter int DEBOUNCE = 20
) (
    input  logic       clk_scan,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [7:0] num_input,
    output logic [1:0] op_display,
    output logic       eq_pulse,
    output logic       clr_pulse
);

    localparam logic [7:0] C_CNT_LAST = 8'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_row, w_row_nxt;
    logic [1:0]  r_col_idx, w_col_idx_nxt;
    logic        w_accept;

    logic [3:0]  w_row_rot;
    logic [1:0]  w_row_idx;
    logic [1:0]  w_first_low;
    logic        w_col_low;
    logic        w_col_idle;
    logic [3:0]  w_code;
    logic [11:0] w_mac;

    logic [3:0]  r_key_code;
    logic        r_key_valid;
    logic [7:0]  r_num;
    logic [1:0]  r_op;
    logic        r_eq;
    logic        r_clr;

    assign w_row_rot  = {r_row[2:0], r_row[3]};
    assign w_col_low  = ~col[r_col_idx];
    assign w_col_idle = (col == 4'b1111);

    // Lowest-index low column wins when several columns read low.
    always_comb begin
        w_first_low = 2'd3;
        if (!col[0])      w_first_low = 2'd0;
        else if (!col[1]) w_first_low = 2'd1;
        else if (!col[2]) w_first_low = 2'd2;
    end

    always_comb begin
        w_row_idx = 2'd0;
        case (r_row)
            4'b1110: w_row_idx = 2'd0;
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            4'b0111: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
    end

    // Key code from the frozen row and the latched column.
    always_comb begin
        w_code = 4'd15;
        case ({w_row_idx, r_col_idx})
            4'd0:    w_code = 4'd1;
            4'd1:    w_code = 4'd2;
            4'd2:    w_code = 4'd3;
            4'd3:    w_code = 4'd10;
            4'd4:    w_code = 4'd4;
            4'd5:    w_code = 4'd5;
            4'd6:    w_code = 4'd6;
            4'd7:    w_code = 4'd11;
            4'd8:    w_code = 4'd7;
            4'd9:    w_code = 4'd8;
            4'd10:   w_code = 4'd9;
            4'd11:   w_code = 4'd12;
            4'd12:   w_code = 4'd13;
            4'd13:   w_code = 4'd0;
            4'd14:   w_code = 4'd14;
            default: w_code = 4'd15;
        endcase
    end

    // Scan / debounce state machine: register process
    always_ff @(posedge clk_scan or posedge rst) begin
        if (rst) begin
            r_state   <= ST_SCAN;
            r_cnt     <= 8'd0;
            r_row     <= 4'b1110;
            r_col_idx <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_row     <= w_row_nxt;
            r_col_idx <= w_col_idx_nxt;
        end
    end

    // Scan / debounce state machine: next-state process
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_row_nxt     = r_row;
        w_col_idx_nxt = r_col_idx;
        w_accept      = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (w_col_idle) begin
                    w_row_nxt = w_row_rot;
                end else begin
                    w_col_idx_nxt = w_first_low;
                    w_cnt_nxt     = 8'd0;
                    w_state_nxt   = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (w_col_low) begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_accept    = 1'b1;
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = ST_PRESSED;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end else begin
                    // Bounce: drop the candidate and continue from the next row.
                    w_cnt_nxt   = 8'd0;
                    w_row_nxt   = w_row_rot;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_PRESSED: begin
                if (w_col_idle) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_col_idle) begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end else begin
                    w_cnt_nxt = 8'd0;
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Widened so the overflow test sees the true value (max 255*10+9).
    assign w_mac = ({4'd0, r_num} * 12'd10) + {8'd0, w_code};

    // Operand / operation registers and output pulses
    always_ff @(posedge clk_scan or posedge rst) begin
        if (rst) begin
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_num       <= 8'd0;
            r_op        <= 2'd0;
            r_eq        <= 1'b0;
            r_clr       <= 1'b0;
        end else begin
            r_key_valid <= w_accept;
            r_eq        <= 1'b0;
            r_clr       <= 1'b0;
            if (w_accept) begin
                r_key_code <= w_code;
                if (w_code <= 4'd9) begin
                    if (w_mac <= 12'd255) begin
                        r_num <= w_mac[7:0];
                    end
                end else begin
                    case (w_code)
                        4'd10:   r_op <= 2'd1;
                        4'd11:   r_op <= 2'd2;
                        4'd12:   r_op <= 2'd3;
                        4'd13: begin
                            r_num <= 8'd0;
                            r_op  <= 2'd0;
                            r_clr <= 1'b1;
                        end
                        4'd14:   r_eq <= 1'b1;
                        default: ;
                    endcase
                end
            end else if (r_eq) begin
                // Entry is held for the = cycle, then cleared.
                r_num <= 8'd0;
                r_op  <= 2'd0;
            end
        end
    end

    assign row        = r_row;
    assign key_code   = r_key_code;
    assign key_valid  = r_key_valid;
    assign num_input  = r_num;
    assign op_display = r_op;
    assign eq_pulse   = r_eq;
    assign clr_pulse  = r_clr;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_entry
//  Description : Directed self-checking bench for keypad_entry. A small
//                keypad model pulls column lines low when a held key's row
//                is driven. Each scenario task checks its own results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry;

    logic       clk_scan;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic [7:0] num_input;
    logic [1:0] op_display;
    logic       eq_pulse;
    logic       clr_pulse;

    keypad_entry #(.DEBOUNCE(20)) dut (
        .clk_scan   (clk_scan),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .num_input  (num_input),
        .op_display (op_display),
        .eq_pulse   (eq_pulse),
        .clr_pulse  (clr_pulse)
    );

    initial clk_scan = 1'b0;
    always #5 clk_scan = ~clk_scan;

    // Keypad model: up to two keys held at once
    logic       key_down, key2_down;
    logic [1:0] key_r, key_c, key2_r, key2_c;

    always_comb begin
        col = 4'b1111;
        if (key_down && !row[key_r])   col[key_c]  = 1'b0;
        if (key2_down && !row[key2_r]) col[key2_c] = 1'b0;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Observations gathered while stepping
    int         kv_cnt, eq_cnt, clr_cnt;
    logic [3:0] last_code;
    logic [7:0] eq_num, post_num;
    logic [1:0] eq_op, post_op;
    logic       eq_kv, clr_kv, prev_eq;

    task automatic clear_obs();
        kv_cnt = 0; eq_cnt = 0; clr_cnt = 0;
        last_code = 4'hx; eq_num = 8'hx; post_num = 8'hx;
        eq_op = 2'bx; post_op = 2'bx; eq_kv = 1'b0; clr_kv = 1'b0;
        prev_eq = 1'b0;
    endtask

    // Advance n cycles, sampling outputs on each falling edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_scan);
            @(negedge clk_scan);
            if (prev_eq) begin
                post_num = num_input;
                post_op  = op_display;
            end
            if (key_valid) begin
                kv_cnt++;
                last_code = key_code;
            end
            if (eq_pulse) begin
                eq_cnt++;
                eq_num = num_input;
                eq_op  = op_display;
                eq_kv  = key_valid;
            end
            if (clr_pulse) begin
                clr_cnt++;
                clr_kv = key_valid;
            end
            prev_eq = eq_pulse;
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_r = r; key_c = c;
        clear_obs();
        key_down = 1'b1;
        run_cycles(25);
        key_down = 1'b0;
        run_cycles(25);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_down = 1'b0; key2_down = 1'b0;
        key_r = 2'd0; key_c = 2'd0; key2_r = 2'd0; key2_c = 2'd0;
        clear_obs();
        repeat (3) @(negedge clk_scan);
        n_tests++; if (row !== 4'b1110) begin n_fail++; $display("FAIL reset_row: got %b expected 1110", row); end
        n_tests++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_key_code: got %0d expected 0", key_code); end
        n_tests++; if ({key_valid, eq_pulse, clr_pulse} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {key_valid, eq_pulse, clr_pulse}); end
        n_tests++; if (num_input !== 8'd0 || op_display !== 2'd0) begin n_fail++; $display("FAIL reset_entry: got num %0d op %0d expected 0 0", num_input, op_display); end
    endtask

    task automatic test_idle();
        logic [3:0] exp_row;
        int bad;
        exp_row = 4'b1110;
        bad = 0;
        rst = 1'b0;
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (row !== exp_row) begin n_fail++; $display("FAIL idle_row[%0d]: got %b expected %b", i, row, exp_row); end
            run_cycles(1);
            exp_row = {exp_row[2:0], exp_row[3]};
        end
        n_tests++; if (kv_cnt + eq_cnt + clr_cnt != 0) begin n_fail++; $display("FAIL idle_pulses: got %0d expected 0", kv_cnt + eq_cnt + clr_cnt); end
    endtask

    task automatic test_key5();
        press(2'd1, 2'd1);
        n_tests++; if (kv_cnt != 1) begin n_fail++; $display("FAIL key5_valid_count: got %0d expected 1", kv_cnt); end
        n_tests++; if (last_code !== 4'd5) begin n_fail++; $display("FAIL key5_code: got %0d expected 5", last_code); end
        n_tests++; if (num_input !== 8'd5) begin n_fail++; $display("FAIL key5_num: got %0d expected 5", num_input); end
    endtask

    task automatic test_clear();
        press(2'd3, 2'd0);
        n_tests++; if (clr_cnt != 1 || !clr_kv) begin n_fail++; $display("FAIL clear_pulse: got count %0d with_valid %0b expected 1 1", clr_cnt, clr_kv); end
        n_tests++; if (last_code !== 4'd13) begin n_fail++; $display("FAIL clear_code: got %0d expected 13", last_code); end
        n_tests++; if (num_input !== 8'd0 || op_display !== 2'd0) begin n_fail++; $display("FAIL clear_entry: got num %0d op %0d expected 0 0", num_input, op_display); end
    endtask

    task automatic test_bounce();
        key_r = 2'd0; key_c = 2'd0;
        clear_obs();
        key_down = 1'b1; run_cycles(10);
        key_down = 1'b0; run_cycles(1);
        key_down = 1'b1; run_cycles(25);
        key_down = 1'b0; run_cycles(25);
        n_tests++; if (kv_cnt != 1) begin n_fail++; $display("FAIL bounce_valid_count: got %0d expected 1", kv_cnt); end
        n_tests++; if (last_code !== 4'd1) begin n_fail++; $display("FAIL bounce_code: got %0d expected 1", last_code); end
        n_tests++; if (num_input !== 8'd1) begin n_fail++; $display("FAIL bounce_num: got %0d expected 1", num_input); end
    endtask

    // Keys 1 and 2 (same row) held together: lowest column wins, one event.
    task automatic test_second_key();
        key2_r = 2'd0; key2_c = 2'd1; key2_down = 1'b1;
        press(2'd0, 2'd0);
        key2_down = 1'b0;
        run_cycles(25);
        n_tests++; if (kv_cnt != 1 || last_code !== 4'd1) begin n_fail++; $display("FAIL two_keys: got count %0d code %0d expected 1 1", kv_cnt, last_code); end
        n_tests++; if (num_input !== 8'd11) begin n_fail++; $display("FAIL two_keys_num: got %0d expected 11", num_input); end
    endtask

    task automatic test_sequence();
        press(2'd3, 2'd0);
        press(2'd0, 2'd1);
        n_tests++; if (num_input !== 8'd2) begin n_fail++; $display("FAIL seq_2: got %0d expected 2", num_input); end
        press(2'd1, 2'd1);
        n_tests++; if (num_input !== 8'd25) begin n_fail++; $display("FAIL seq_25: got %0d expected 25", num_input); end
        press(2'd1, 2'd1);
        n_tests++; if (num_input !== 8'd255) begin n_fail++; $display("FAIL seq_255: got %0d expected 255", num_input); end
        press(2'd2, 2'd2);
        n_tests++; if (num_input !== 8'd255 || kv_cnt != 1 || last_code !== 4'd9) begin n_fail++; $display("FAIL seq_overflow: got num %0d count %0d code %0d expected 255 1 9", num_input, kv_cnt, last_code); end
        press(2'd2, 2'd3);
        n_tests++; if (op_display !== 2'd3 || num_input !== 8'd255) begin n_fail++; $display("FAIL seq_mul: got op %0d num %0d expected 3 255", op_display, num_input); end
        press(2'd0, 2'd3);
        n_tests++; if (op_display !== 2'd1) begin n_fail++; $display("FAIL seq_op_overwrite: got %0d expected 1", op_display); end
    endtask

    task automatic test_unused();
        press(2'd3, 2'd3);
        n_tests++; if (kv_cnt != 1 || last_code !== 4'd15) begin n_fail++; $display("FAIL unused_key: got count %0d code %0d expected 1 15", kv_cnt, last_code); end
        n_tests++; if (num_input !== 8'd255 || op_display !== 2'd1 || eq_cnt != 0 || clr_cnt != 0) begin n_fail++; $display("FAIL unused_effect: got num %0d op %0d eq %0d clr %0d expected 255 1 0 0", num_input, op_display, eq_cnt, clr_cnt); end
    endtask

    task automatic test_equals();
        press(2'd3, 2'd0);
        press(2'd1, 2'd0);
        press(2'd0, 2'd1);
        press(2'd0, 2'd3);
        n_tests++; if (num_input !== 8'd42 || op_display !== 2'd1) begin n_fail++; $display("FAIL eq_setup: got num %0d op %0d expected 42 1", num_input, op_display); end
        press(2'd3, 2'd2);
        n_tests++; if (eq_cnt != 1 || !eq_kv) begin n_fail++; $display("FAIL eq_pulse: got cycles %0d with_valid %0b expected 1 1", eq_cnt, eq_kv); end
        n_tests++; if (eq_num !== 8'd42 || eq_op !== 2'd1) begin n_fail++; $display("FAIL eq_hold: got num %0d op %0d expected 42 1", eq_num, eq_op); end
        n_tests++; if (post_num !== 8'd0 || post_op !== 2'd0) begin n_fail++; $display("FAIL eq_clear: got num %0d op %0d expected 0 0", post_num, post_op); end
        n_tests++; if (last_code !== 4'd14) begin n_fail++; $display("FAIL eq_code: got %0d expected 14", last_code); end
    endtask

    task automatic test_reset_held();
        press(2'd2, 2'd0);
        key_r = 2'd3; key_c = 2'd1;
        clear_obs();
        key_down = 1'b1;
        run_cycles(25);
        n_tests++; if (kv_cnt != 1 || num_input !== 8'd70) begin n_fail++; $display("FAIL held0_setup: got count %0d num %0d expected 1 70", kv_cnt, num_input); end
        // Assert reset between edges: outputs must clear without a clock.
        #1 rst = 1'b1;
        #1;
        n_tests++; if (row !== 4'b1110 || num_input !== 8'd0 || op_display !== 2'd0 || key_code !== 4'd0) begin n_fail++; $display("FAIL async_reset: got row %b num %0d op %0d code %0d expected 1110 0 0 0", row, num_input, op_display, key_code); end
        clear_obs();
        run_cycles(3);
        n_tests++; if (kv_cnt != 0) begin n_fail++; $display("FAIL reset_no_valid: got %0d expected 0", kv_cnt); end
        rst = 1'b0;
        run_cycles(30);
        n_tests++; if (kv_cnt != 1 || last_code !== 4'd0 || num_input !== 8'd0) begin n_fail++; $display("FAIL held0_redetect: got count %0d code %0d num %0d expected 1 0 0", kv_cnt, last_code, num_input); end
        key_down = 1'b0;
        run_cycles(25);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_key5();
        test_clear();
        test_bounce();
        test_second_key();
        test_sequence();
        test_unused();
        test_equals();
        test_reset_held();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 20, meaning the number of consecutive clk_scan samples needed to accept a press or release (valid range 2..255).
REQ-002 SHALL have port clk_scan, input, 1 bit: 1 kHz scan clock; the only clock in the block.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port row, output, 4 bits: keypad row drive, active-low one-hot.
REQ-005 SHALL have port col, input, 4 bits: keypad column sense, active-low (board pull-ups).
REQ-006 SHALL have port key_code, output, 4 bits: code of the last accepted key.
REQ-007 SHALL have port key_valid, output, 1 bit: one-cycle pulse per accepted key.
REQ-008 SHALL have port num_input, output, 8 bits: operand currently being entered, binary.
REQ-009 SHALL have port op_display, output, 2 bits: pending operation, 0 = none, 1 = +, 2 = -, 3 = *.
REQ-010 SHALL have port eq_pulse, output, 1 bit: one-cycle pulse on the = key.
REQ-011 SHALL have port clr_pulse, output, 1 bit: one-cycle pulse on the C key.

Function
REQ-012 SHALL map keys by [row, col] to these key_codes:
- r0: 1, 2, 3, + (codes 1, 2, 3, 10)
- r1: 4, 5, 6, - (codes 4, 5, 6, 11)
- r2: 7, 8, 9, * (codes 7, 8, 9, 12)
- r3: C, 0, =, unused (codes 13, 0, 14, 15)
REQ-013 SHALL implement an FSM with states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-014 SCAN: col SHALL be sampled at each edge against the row value driven during the preceding cycle.
- If col == 4'b1111, row SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Otherwise the FSM SHALL freeze row, latch the lowest-index low column, clear the counter and go to DEBOUNCE.
REQ-015 DEBOUNCE: the counter SHALL increment while the latched column bit stays low.
- If that bit is high at any sample, the FSM SHALL return to SCAN with no key output, and rotation SHALL resume from the next row.
REQ-016 When DEBOUNCE consecutive low samples are reached, the FSM SHALL go to PRESSED.
- On that same edge key_code SHALL update and key_valid SHALL go high for exactly one cycle.
REQ-017 PRESSED: row SHALL stay frozen, and no further key_valid SHALL be produced, however long the key is held.
- On col == 4'b1111 the FSM SHALL go to RELEASE with the counter cleared.
REQ-018 RELEASE: the FSM SHALL require DEBOUNCE consecutive col == 4'b1111 samples, then go to SCAN.
- Any low sample SHALL clear the counter and keep the FSM in RELEASE.
REQ-019 A digit key d SHALL set num_input <= num_input*10 + d on the key_valid edge, computed at ≥12 bits.
- If the result exceeds 255, num_input SHALL be left unchanged (digit ignored, no wrap).
REQ-020 Keys +, - and * SHALL set op_display to 1, 2 or 3 respectively.
- num_input SHALL be unchanged; a later operator key SHALL overwrite op_display.
REQ-021 Key = SHALL assert eq_pulse for one cycle, coincident with key_valid.
- num_input and op_display SHALL hold during that cycle and clear to 0 on the following edge.
REQ-022 Key C SHALL clear num_input and op_display on the key_valid edge and assert clr_pulse for one cycle.
REQ-023 key_code 15 SHALL assert key_valid only, with no other effect.
REQ-024 A second key pressed while the FSM is in DEBOUNCE, PRESSED or RELEASE SHALL be ignored; only the latched column is monitored.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On rst high, asynchronously, the block SHALL set:
- row = 4'b1110, FSM = SCAN, counter = 0
- key_code = 0, key_valid = 0, num_input = 0, op_display = 0, eq_pulse = 0, clr_pulse = 0
REQ-027 Reset asserted mid-debounce or while a key is held SHALL abort the operation with no pulse.
- After release of rst, a still-held key SHALL be detected afresh from SCAN.

Verification
REQ-028 Idle, col = 1111 for 8 cycles -> row sequence 1110, 1101, 1011, 0111, 1110, ...; no pulses.
REQ-029 Key "5" (r1 c1) held 25 cycles, then released -> exactly one key_valid with key_code = 5; num_input = 5.
REQ-030 Bounce: r0 c0 low for 10 cycles, high for 1, then low for 25 -> exactly one key_valid, key_code = 1, num_input = 1.
REQ-031 Sequence 2, 5, 5, 9 -> num_input = 2, 25, 255, then 255 (9 ignored); then * -> op_display = 3.
REQ-032 With num_input = 42 and op_display = 1, press = -> eq_pulse high 1 cycle while num_input = 42; next cycle num_input = 0, op_display = 0.
REQ-033 rst pulsed while the 0 key is held in PRESSED -> all outputs at reset values, no key_valid; the held key yields one key_valid DEBOUNCE cycles after rst falls and its row is scanned.
